// File: rtl/adc_rd_pkg.sv
// Shared constants for the ADC081S101-class serial read path.
// FSM state encoding, serial-clock divider phases and default parameters.
package adc_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        QUIET = 2'd2
    } state_e;

    // Both the shift and the bit advance happen on the last divider phase,
    // just before adc_clk falls and the ADC moves to its next bit.
    localparam logic [1:0] DIV_LAST   = 2'd3;
    localparam logic [1:0] DIV_SAMPLE = 2'd3;

    localparam int DEF_DATA_BITS  = 8;
    localparam int DEF_LEAD_BITS  = 3;
    localparam int DEF_FRAME_BITS = 16;
    localparam int DEF_QUIET_CYC  = 4;

endpackage

// File: rtl/adc_sclk_gen.sv
// Serial clock generator: divides sp_clk by 4 while enabled and counts frame bits.
// Emits a capture strobe per bit and a last-bit strobe at the end of the frame.
module adc_sclk_gen
    import adc_rd_pkg::*;
#(
    parameter int FRAME_BITS = DEF_FRAME_BITS
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic adc_clk_o,
    output logic sample_o,
    output logic last_o
);

    localparam int BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

    logic [1:0]    div_cnt_q, div_cnt_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;

    assign adc_clk_o = div_cnt_q[1];
    assign sample_o  = en_i && (div_cnt_q == DIV_SAMPLE);
    assign last_o    = en_i && (div_cnt_q == DIV_LAST) && (bit_cnt_q == BW'(FRAME_BITS - 1));

    always_comb begin
        div_cnt_d = en_i ? div_cnt_q + 2'd1 : 2'd0;
        bit_cnt_d = bit_cnt_q;
        if (!en_i) begin
            bit_cnt_d = '0;
        end else if (div_cnt_q == DIV_LAST) begin
            bit_cnt_d = last_o ? '0 : bit_cnt_q + BW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt_q <= 2'd0;
            bit_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/adc_rd.sv
// ADC081S101-class serial read: one framed conversion per request, parallel sample out.
// Optional leading-zero frame check is built when ADC_LEAD_CHK_EN is defined.
module adc_rd
    import adc_rd_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int LEAD_BITS  = DEF_LEAD_BITS,
    parameter int FRAME_BITS = DEF_FRAME_BITS,
    parameter int QUIET_CYC  = DEF_QUIET_CYC
) (
    input  logic                 sp_clk,
    input  logic                 sp_rst_n,
    input  logic                 conv_req,
    input  logic                 adc_sdata,
    output logic                 adc_clk,
    output logic                 adc_cs_n,
    output logic [DATA_BITS-1:0] adc_data,
    output logic                 adc_data_val,
    output logic                 busy,
    output logic                 frame_err
);

    localparam int QW = (QUIET_CYC > 1) ? $clog2(QUIET_CYC) : 1;

    // Handshake: conv_req is a one-cycle pulse (no ready; requests while busy
    // collapse into one pending conversion); adc_data_val is a one-cycle
    // strobe with adc_data valid on that same cycle and held afterwards.
    state_e                state_q, state_d;
    logic                  pending_q, pending_d;
    logic                  cs_n_q, cs_n_d;
    logic                  sdata_q;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0]  data_q, data_d;
    logic                  val_q, val_d;
    logic [QW-1:0]         q_cnt_q, q_cnt_d;
    logic                  sample, last;
    logic                  unused_msb;

    adc_sclk_gen #(
        .FRAME_BITS(FRAME_BITS)
    ) u_sclk (
        .clk_i    (sp_clk),
        .rst_ni   (sp_rst_n),
        .en_i     (state_q == CONV),
        .adc_clk_o(adc_clk),
        .sample_o (sample),
        .last_o   (last)
    );

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        cs_n_d    = cs_n_q;
        shift_d   = shift_q;
        data_d    = data_q;
        val_d     = 1'b0;
        q_cnt_d   = q_cnt_q;
        if (sample) begin
            shift_d = {shift_q[FRAME_BITS-2:0], sdata_q};
        end
        case (state_q)
            IDLE: begin
                if (conv_req || pending_q) begin
                    state_d   = CONV;
                    cs_n_d    = 1'b0;
                    pending_d = 1'b0;
                end
            end
            CONV: begin
                if (conv_req) pending_d = 1'b1;
                if (last) begin
                    state_d = QUIET;
                    cs_n_d  = 1'b1;
                    q_cnt_d = '0;
                    data_d  = shift_d[FRAME_BITS-1-LEAD_BITS -: DATA_BITS];
                    val_d   = 1'b1;
                end
            end
            QUIET: begin
                if (conv_req) pending_d = 1'b1;
                if (q_cnt_q == QW'(QUIET_CYC - 1)) begin
                    state_d = IDLE;
                end else begin
                    q_cnt_d = q_cnt_q + QW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sp_clk or negedge sp_rst_n) begin
        if (!sp_rst_n) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            cs_n_q    <= 1'b1;
            sdata_q   <= 1'b0;
            shift_q   <= '0;
            data_q    <= '0;
            val_q     <= 1'b0;
            q_cnt_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            cs_n_q    <= cs_n_d;
            sdata_q   <= adc_sdata;
            shift_q   <= shift_d;
            data_q    <= data_d;
            val_q     <= val_d;
            q_cnt_q   <= q_cnt_d;
        end
    end

`ifdef ADC_LEAD_CHK_EN
    logic err_q;

    // Re-evaluated at every frame completion, so a clean frame clears it.
    always_ff @(posedge sp_clk or negedge sp_rst_n) begin
        if (!sp_rst_n) begin
            err_q <= 1'b0;
        end else if (val_d) begin
            err_q <= |shift_d[FRAME_BITS-1 -: LEAD_BITS];
        end
    end

    assign frame_err = err_q;
`else
    assign frame_err = 1'b0;
`endif

    // The oldest frame bit is consumed from shift_d; the register copy is never read.
    assign unused_msb   = shift_q[FRAME_BITS-1];
    assign adc_cs_n     = cs_n_q;
    assign adc_data     = data_q;
    assign adc_data_val = val_q;
    assign busy         = (state_q != IDLE);

endmodule
